ahb_input_stage: RTL and testbench

- Per-master address-phase holding stage at the master-facing edge of the AHB-Lite interconnect.
- Captures a master's address/control when the downstream arbiter/decoder cannot accept it in the same cycle.
- Stalls the master via hreadyout_m until the held transfer is accepted, then relays data-phase HREADY/HRESP back.
- Write/read data paths bypass this block.

---
 rtl/ahb_input_stage.sv | 106 ++++++++++
 tb/tb_ahb_input_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_input_stage.sv
// AHB-Lite master-side address-phase holding stage.
// Holds a refused address phase and stalls the master until accepted.
module ahb_input_stage #(
  parameter int AW = 32,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsel_m,
  input  logic [AW-1:0] haddr_m,
  input  logic [1:0]    htrans_m,
  input  logic          hwrite_m,
  input  logic [2:0]    hsize_m,
  input  logic [2:0]    hburst_m,
  input  logic [PW-1:0] hprot_m,
  input  logic          hready_m,
  output logic          hreadyout_m,
  output logic          hresp_m,
  output logic [AW-1:0] haddr_s,
  output logic [1:0]    htrans_s,
  output logic          hwrite_s,
  output logic [2:0]    hsize_s,
  output logic [2:0]    hburst_s,
  output logic [PW-1:0] hprot_s,
  input  logic          s_addr_ack,
  input  logic          hready_s,
  input  logic          hresp_s
);

  logic          r_pend;
  logic          r_dphase;
  logic [AW-1:0] r_haddr;
  logic [1:0]    r_htrans;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [2:0]    r_hburst;
  logic [PW-1:0] r_hprot;

  logic w_av;
  logic w_acc;
  logic w_cap;

  assign w_av  = hsel_m & htrans_m[1] & hready_m;
  assign w_acc = s_addr_ack & (r_pend | w_av);
  // a new phase arriving while one is held is ignored
  assign w_cap = w_av & ~s_addr_ack & ~r_pend;

  // capture refused address phase; release once downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= 2'b00;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_hburst <= 3'd0;
      r_hprot  <= '0;
    end else if (w_cap) begin
      r_pend   <= 1'b1;
      r_haddr  <= haddr_m;
      r_htrans <= htrans_m;
      r_hwrite <= hwrite_m;
      r_hsize  <= hsize_m;
      r_hburst <= hburst_m;
      r_hprot  <= hprot_m;
    end else if (r_pend && s_addr_ack) begin
      r_pend   <= 1'b0;
    end
  end

  // data phase open from acceptance until downstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dphase <= 1'b0;
    end else if (w_acc) begin
      r_dphase <= 1'b1;
    end else if (hready_s) begin
      r_dphase <= 1'b0;
    end
  end

  // downstream mux and master-side response
  always_comb begin
    haddr_s     = haddr_m;
    htrans_s    = w_av ? htrans_m : 2'b00;
    hwrite_s    = hwrite_m;
    hsize_s     = hsize_m;
    hburst_s    = hburst_m;
    hprot_s     = hprot_m;
    hreadyout_m = 1'b1;
    hresp_m     = 1'b0;
    if (r_pend) begin
      haddr_s     = r_haddr;
      htrans_s    = r_htrans;
      hwrite_s    = r_hwrite;
      hsize_s     = r_hsize;
      hburst_s    = r_hburst;
      hprot_s     = r_hprot;
      hreadyout_m = 1'b0;
    end else if (r_dphase) begin
      hreadyout_m = hready_s;
      hresp_m     = hresp_s;
    end
  end

endmodule

// File: tb/tb_ahb_input_stage.sv
// Scoreboard bench for ahb_input_stage.
// Reference model tracks held transfers and open data phases.
module tb_ahb_input_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel_m = 1'b0;
  logic [31:0] haddr_m = '0;
  logic [1:0]  htrans_m = '0;
  logic        hwrite_m = 1'b0;
  logic [2:0]  hsize_m = '0;
  logic [2:0]  hburst_m = '0;
  logic [3:0]  hprot_m = '0;
  logic        hready_m = 1'b0;
  logic        s_addr_ack = 1'b0;
  logic        hready_s = 1'b0;
  logic        hresp_s = 1'b0;
  logic        hreadyout_m;
  logic        hresp_m;
  logic [31:0] haddr_s;
  logic [1:0]  htrans_s;
  logic        hwrite_s;
  logic [2:0]  hsize_s;
  logic [2:0]  hburst_s;
  logic [3:0]  hprot_s;

  ahb_input_stage #(.AW(32), .PW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .hsel_m(hsel_m), .haddr_m(haddr_m),
    .htrans_m(htrans_m), .hwrite_m(hwrite_m),
    .hsize_m(hsize_m), .hburst_m(hburst_m),
    .hprot_m(hprot_m), .hready_m(hready_m),
    .hreadyout_m(hreadyout_m), .hresp_m(hresp_m),
    .haddr_s(haddr_s), .htrans_s(htrans_s),
    .hwrite_s(hwrite_s), .hsize_s(hsize_s),
    .hburst_s(hburst_s), .hprot_s(hprot_s),
    .s_addr_ack(s_addr_ack), .hready_s(hready_s),
    .hresp_s(hresp_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } xfer_t;

  typedef struct {
    xfer_t x;
    logic  rdy;
    logic  rsp;
  } exp_t;

  xfer_t hold_q[$];
  exp_t  exp_q[$];
  int    busy_dp = 0;
  int    total = 0;
  int    bad = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endfunction

  function automatic xfer_t live();
    xfer_t x;
    x.addr  = haddr_m;
    x.trans = htrans_m;
    x.write = hwrite_m;
    x.size  = hsize_m;
    x.burst = hburst_m;
    x.prot  = hprot_m;
    return x;
  endfunction

  function automatic bit new_xfer();
    return hsel_m && (htrans_m == 2'b10 || htrans_m == 2'b11) && hready_m;
  endfunction

  // expected outputs for the inputs currently applied
  function automatic exp_t predict();
    exp_t e;
    if (hold_q.size() > 0) begin
      e.x   = hold_q[0];
      e.rdy = 1'b0;
      e.rsp = 1'b0;
    end else begin
      e.x = live();
      if (!new_xfer()) e.x.trans = 2'b00;
      e.rdy = (busy_dp > 0) ? hready_s : 1'b1;
      e.rsp = (busy_dp > 0) ? hresp_s : 1'b0;
    end
    return e;
  endfunction

  // advance the model across a clock edge
  function automatic void commit();
    bit took;
    if (!rst_n) begin
      hold_q.delete();
      busy_dp = 0;
      return;
    end
    took = s_addr_ack && (hold_q.size() > 0 || new_xfer());
    if (hold_q.size() > 0) begin
      if (s_addr_ack) void'(hold_q.pop_front());
    end else if (new_xfer() && !s_addr_ack) begin
      hold_q.push_back(live());
    end
    if (took) busy_dp = 1;
    else if (hready_s) busy_dp = 0;
  endfunction

  task automatic set(input bit sel, input logic [31:0] a,
                     input logic [1:0] t, input bit w,
                     input logic [2:0] sz, input logic [2:0] b,
                     input logic [3:0] p, input bit hrm,
                     input bit ack, input bit hrs, input bit rsp);
    hsel_m = sel; haddr_m = a; htrans_m = t; hwrite_m = w;
    hsize_m = sz; hburst_m = b; hprot_m = p; hready_m = hrm;
    s_addr_ack = ack; hready_s = hrs; hresp_s = rsp;
    if (!rst_n) begin
      hold_q.delete();
      busy_dp = 0;
    end
    exp_q.push_back(predict());
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  // monitor: compare DUT against queued expectations
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("haddr_s", haddr_s, e.x.addr);
        chk("htrans_s", {30'd0, htrans_s}, {30'd0, e.x.trans});
        chk("hwrite_s", {31'd0, hwrite_s}, {31'd0, e.x.write});
        chk("hsize_s", {29'd0, hsize_s}, {29'd0, e.x.size});
        chk("hburst_s", {29'd0, hburst_s}, {29'd0, e.x.burst});
        chk("hprot_s", {28'd0, hprot_s}, {28'd0, e.x.prot});
        chk("hreadyout_m", {31'd0, hreadyout_m}, {31'd0, e.rdy});
        chk("hresp_m", {31'd0, hresp_m}, {31'd0, e.rsp});
      end
    end
  end

  initial begin
    int n;
    @(posedge clk); #1;
    // reset
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("rst_rdy", {31'd0, hreadyout_m}, 32'd1);
    chk("rst_trans", {30'd0, htrans_s}, 32'd0);
    tick();
    rst_n = 1'b1;
    // pass-through read
    set(1, 32'h1000, 2'b10, 0, 2, 0, 3, 1, 1, 1, 0); #2;
    chk("pt_addr", haddr_s, 32'h1000);
    chk("pt_trans", {30'd0, htrans_s}, 32'd2);
    tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); #2;
    chk("pt_wait", {31'd0, hreadyout_m}, 32'd0);
    tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0); #2;
    chk("pt_done", {31'd0, hreadyout_m}, 32'd1);
    tick();
    // hold a refused write
    set(1, 32'h2000_0040, 2'b10, 1, 2, 1, 2, 1, 0, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      set(1, 32'hDEAD, 2'b00, 0, 0, 0, 0, 0, i == 2, 1, 0); #2;
      chk("hold_addr", haddr_s, 32'h2000_0040);
      chk("hold_rdy", {31'd0, hreadyout_m}, 32'd0);
      tick();
    end
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    // INCR4 pipelined burst
    for (int i = 0; i < 4; i++) begin
      set(1, 32'h3000 + 32'(i * 4), (i == 0) ? 2'b10 : 2'b11,
          0, 2, 3, 3, 1, 1, 1, 0); #2;
      chk("burst_rdy", {31'd0, hreadyout_m}, 32'd1);
      tick();
    end
    set(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    // two-cycle ERROR
    set(1, 32'h4000, 2'b10, 1, 2, 0, 3, 1, 1, 1, 0); tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("err1_rsp", {31'd0, hresp_m}, 32'd1);
    chk("err1_rdy", {31'd0, hreadyout_m}, 32'd0);
    tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1); #2;
    chk("err2_rsp", {31'd0, hresp_m}, 32'd1);
    chk("err2_rdy", {31'd0, hreadyout_m}, 32'd1);
    tick();
    // BUSY / unselected filtering
    set(1, 32'h5000, 2'b01, 0, 2, 1, 0, 1, 0, 1, 0); #2;
    chk("busy_trans", {30'd0, htrans_s}, 32'd0);
    tick();
    set(0, 32'h6000, 2'b10, 0, 2, 0, 0, 1, 0, 1, 0); #2;
    chk("nosel_trans", {30'd0, htrans_s}, 32'd0);
    tick();
    set(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0); #2;
    chk("nosel_rdy", {31'd0, hreadyout_m}, 32'd1);
    tick();
    // reset while holding
    set(1, 32'h7000, 2'b10, 0, 2, 0, 0, 1, 0, 1, 0); tick();
    rst_n = 1'b0;
    set(1, 32'h7000, 2'b00, 0, 2, 0, 0, 0, 0, 1, 1); #2;
    chk("mrst_trans", {30'd0, htrans_s}, 32'd0);
    chk("mrst_rdy", {31'd0, hreadyout_m}, 32'd1);
    chk("mrst_rsp", {31'd0, hresp_m}, 32'd0);
    tick();
    rst_n = 1'b1;
    set(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0); #2;
    chk("post_rst_rdy", {31'd0, hreadyout_m}, 32'd1);
    tick();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      set($urandom_range(0, 7) != 0, $urandom,
          2'($urandom_range(0, 3)), 1'($urandom),
          3'($urandom_range(0, 2)), 3'($urandom),
          4'($urandom), $urandom_range(0, 5) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
          $urandom_range(0, 7) == 0);
      tick();
    end
    rst_n = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
